// File: rtl/exe_muldiv_unit.sv
// ----------------------------------------------------------------------------
// exe_muldiv_unit
//   Iterative radix-2 multiply/divide for the EXE stage. One op in flight:
//   IDLE -> CALC (WIDTH steps) -> FIXUP (sign correction, Hi/Lo write) -> DONE.
//   Outputs are registered from the state, so Busy rises one cycle after the
//   launching edge and Done appears WIDTH+2 edges after Start is sampled.
// Ports
//   CLK, RST_N    clock, synchronous active-low reset
//   Start, Op     launch request and opcode (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   A, B          operands (multiplicand/dividend, multiplier/divisor)
//   Flush         abort any in-flight op
//   Busy          op in progress (hazard unit stall)
//   Done          one-cycle completion pulse
//   Div_By_Zero   pulses with Done when a divide had B == 0
//   Hi, Lo        product high/low or remainder/quotient
// ----------------------------------------------------------------------------
module exe_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             Div_By_Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits / dividend->quotient
    logic [WIDTH-1:0]   opb_q, opb_d;         // |multiplicand| or |divisor|
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;   // negate product / quotient
    logic               neg_hi_q, neg_hi_d;   // negate remainder (dividend sign)
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_out_q, dbz_out_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes; signs only matter for MULT/DIV (Op[0]).
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_neg = Op[0] & A[WIDTH-1];
    assign b_neg = Op[0] & B[WIDTH-1];
    assign a_abs = a_neg ? (-A) : A;
    assign b_abs = b_neg ? (-B) : B;

    // One shift-add multiply step.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    // One restoring divide step.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    assign div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, opb_q});
    assign div_sub = WIDTH'(div_sh - {1'b0, opb_q});

    logic [2*WIDTH-1:0] prod_neg;
    assign prod_neg = -{acc_hi_q, acc_lo_q};

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dbz_d     = dbz_q;
        busy_d    = (state_q != S_IDLE);
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                // busy_q still high during the Done cycle, so a Start there is dropped
                if (Start && !busy_q && !Flush) begin
                    is_div_d = Op[1];
                    dbz_d    = Op[1] && (B == '0);
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = Op[1] ? a_neg : (a_neg ^ b_neg);
                    acc_hi_d = '0;
                    acc_lo_d = Op[1] ? a_abs : b_abs;
                    opb_d    = Op[1] ? b_abs : a_abs;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (is_div_q) begin
                    // divide by zero: quotient all ones, remainder restores to A
                    lo_d = dbz_q ? {WIDTH{1'b1}} : (neg_lo_q ? (-acc_lo_q) : acc_lo_q);
                    hi_d = neg_hi_q ? (-acc_hi_q) : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : {acc_hi_q, acc_lo_q};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush aborts any in-flight op without touching Hi/Lo.
        if (Flush && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            dbz_out_d = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Div_By_Zero = dbz_out_q;
    assign Hi          = hi_q;
    assign Lo          = lo_q;

endmodule
